// File: rtl/usb_keyboard_report_rx.sv
// HID boot keyboard report receiver: assembles 8-byte reports and diffs each
// accepted report against the previous one into a queue of press/release events.
module usb_keyboard_report_rx #(
  parameter int EVT_DEPTH = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  input  logic       rx_last,
  output logic [7:0] evt_code,
  output logic       evt_press,
  output logic       evt_valid,
  input  logic       evt_ready,
  output logic [7:0] modifiers,
  output logic       busy,
  output logic       report_err
);

  localparam int AW = $clog2(EVT_DEPTH);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_REL_MOD = 3'd1;
  localparam logic [2:0] S_REL_KEY = 3'd2;
  localparam logic [2:0] S_PRS_MOD = 3'd3;
  localparam logic [2:0] S_PRS_KEY = 3'd4;
  localparam logic [2:0] S_UPDATE  = 3'd5;

  function automatic logic [7:0] slot(input logic [47:0] keys, input logic [2:0] i);
    logic [7:0] r;
    r = 8'h00;
    for (int j = 0; j < 6; j++)
      if (i == 3'(j)) r = keys[8*j +: 8];
    return r;
  endfunction

  function automatic logic has_code(input logic [47:0] keys, input logic [7:0] code);
    logic r;
    r = 1'b0;
    for (int j = 0; j < 6; j++)
      if (keys[8*j +: 8] == code) r = 1'b1;
    return r;
  endfunction

  // True when the slot's code already appeared in a lower-numbered slot.
  function automatic logic dup_before(input logic [47:0] keys, input logic [2:0] i);
    logic       r;
    logic [7:0] c;
    r = 1'b0;
    c = slot(keys, i);
    for (int j = 0; j < 6; j++)
      if ((3'(j) < i) && (keys[8*j +: 8] == c)) r = 1'b1;
    return r;
  endfunction

  logic [3:0]  cnt_q;
  logic        bad_q;
  logic [7:0]  sh_q [0:6];
  logic        err_q, err_d;

  logic [2:0]  state_q;
  logic [2:0]  idx_q;
  logic [7:0]  new_mod_q, prev_mod_q;
  logic [47:0] new_key_q, prev_key_q;

  logic [8:0]  mem_q [0:EVT_DEPTH-1];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [AW:0] fcnt_q;

  logic        pkt_end, pkt_good, rollover, start;
  logic [47:0] rx_keys;
  logic        step_push, step_press, last_step;
  logic [7:0]  step_code;
  logic        full, pop, push, stall;
  logic [8:0]  head;

  assign pkt_end  = rx_valid & rx_last;
  assign pkt_good = (cnt_q == 4'd7) & ~bad_q;
  assign rx_keys  = {rx_data, sh_q[6], sh_q[5], sh_q[4], sh_q[3], sh_q[2]};
  assign rollover = has_code(rx_keys, 8'h01);
  assign busy     = (state_q != S_IDLE);
  assign start    = pkt_end & pkt_good & ~rollover & ~busy;
  assign err_d    = pkt_end & (~pkt_good | (~rollover & busy));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= 4'd0;
      bad_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
      if (rx_valid) begin
        if (rx_last) begin
          cnt_q <= 4'd0;
          bad_q <= 1'b0;
        end else if (cnt_q == 4'd8) begin
          bad_q <= 1'b1;
        end else begin
          cnt_q <= cnt_q + 4'd1;
        end
      end
    end
  end

  // The eighth byte is always the rx_last byte of a good packet, so only 0..6 are buffered.
  always_ff @(posedge clk) begin
    if (rx_valid && !rx_last && (cnt_q < 4'd7))
      sh_q[cnt_q[2:0]] <= rx_data;
    if (start) begin
      new_mod_q <= sh_q[0];
      new_key_q <= rx_keys;
    end
  end

  always_comb begin
    step_push  = 1'b0;
    step_press = 1'b0;
    step_code  = 8'h00;
    last_step  = 1'b0;
    case (state_q)
      S_REL_MOD: begin
        step_code = 8'hE0 | {5'd0, idx_q};
        step_push = prev_mod_q[idx_q] & ~new_mod_q[idx_q];
        last_step = (idx_q == 3'd7);
      end
      S_REL_KEY: begin
        step_code = slot(prev_key_q, idx_q);
        step_push = (step_code != 8'h00) && !has_code(new_key_q, step_code) &&
                    !dup_before(prev_key_q, idx_q);
        last_step = (idx_q == 3'd5);
      end
      S_PRS_MOD: begin
        step_code  = 8'hE0 | {5'd0, idx_q};
        step_press = 1'b1;
        step_push  = ~prev_mod_q[idx_q] & new_mod_q[idx_q];
        last_step  = (idx_q == 3'd7);
      end
      S_PRS_KEY: begin
        step_code  = slot(new_key_q, idx_q);
        step_press = 1'b1;
        step_push  = (step_code != 8'h00) && !has_code(prev_key_q, step_code) &&
                     !dup_before(new_key_q, idx_q);
        last_step  = (idx_q == 3'd5);
      end
      default: ;
    endcase
  end

  assign evt_valid = (fcnt_q != '0);
  assign full      = (fcnt_q == (AW+1)'(EVT_DEPTH));
  assign pop       = evt_valid & evt_ready;
  assign push      = step_push & (~full | pop);
  assign stall     = step_push & ~push;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      idx_q      <= 3'd0;
      prev_mod_q <= 8'h00;
      prev_key_q <= 48'h0;
    end else begin
      case (state_q)
        S_IDLE: begin
          idx_q <= 3'd0;
          if (start) state_q <= S_REL_MOD;
        end
        S_UPDATE: begin
          prev_mod_q <= new_mod_q;
          prev_key_q <= new_key_q;
          state_q    <= S_IDLE;
        end
        default: begin
          if (!stall) begin
            if (last_step) begin
              idx_q   <= 3'd0;
              state_q <= state_q + 3'd1;
            end else begin
              idx_q <= idx_q + 3'd1;
            end
          end
        end
      endcase
    end
  end

  // Pointers wrap naturally because the depth is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      fcnt_q <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + 1'b1;
      if (pop)  rptr_q <= rptr_q + 1'b1;
      case ({push, pop})
        2'b10:   fcnt_q <= fcnt_q + 1'b1;
        2'b01:   fcnt_q <= fcnt_q - 1'b1;
        default: fcnt_q <= fcnt_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= {step_press, step_code};
  end

  assign head       = mem_q[rptr_q];
  assign evt_code   = evt_valid ? head[7:0] : 8'h00;
  assign evt_press  = evt_valid ? head[8] : 1'b0;
  assign modifiers  = prev_mod_q;
  assign report_err = err_q;

endmodule

// File: tb/tb_usb_keyboard_report_rx.sv
// Directed bench for usb_keyboard_report_rx with a small event FIFO so that
// backpressure stalls are reachable.
module tb_usb_keyboard_report_rx;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] rx_data;
  logic       rx_valid, rx_last;
  logic [7:0] evt_code;
  logic       evt_press, evt_valid, evt_ready;
  logic [7:0] modifiers;
  logic       busy, report_err;

  int n_chk  = 0;
  int n_pass = 0;
  int busy_cnt = 0;
  int err_cnt  = 0;
  logic [8:0] evq [$];

  always #5 clk = ~clk;

  usb_keyboard_report_rx #(.EVT_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid), .rx_last(rx_last),
    .evt_code(evt_code), .evt_press(evt_press), .evt_valid(evt_valid),
    .evt_ready(evt_ready), .modifiers(modifiers), .busy(busy), .report_err(report_err)
  );

  // Outputs are stable at the falling edge; a handshake seen here completes on the next rise.
  always @(negedge clk) begin
    if (!rst && evt_valid && evt_ready) evq.push_back({evt_press, evt_code});
    if (!rst && busy) busy_cnt++;
    if (!rst && report_err) err_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic chk_ev(input int base, input int i, input logic [8:0] exp);
    logic [8:0] got;
    got = (base + i < evq.size()) ? evq[base + i] : 9'h1FF;
    chk($sformatf("event%0d", i), {23'd0, got}, {23'd0, exp});
  endtask

  task automatic send(input logic [71:0] pkt, input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      rx_valid = 1'b1;
      rx_last  = (i == n - 1);
      rx_data  = pkt[8*(n-1-i) +: 8];
    end
    @(posedge clk); #1;
    rx_valid = 1'b0;
    rx_last  = 1'b0;
    rx_data  = 8'h00;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 300; i++) begin
      if (!busy && !evt_valid) break;
      @(posedge clk); #1;
    end
    chk("idle_timeout", {31'd0, busy | evt_valid}, 32'd0);
  endtask

  int b0, e0, r0;

  initial begin
    rst = 1'b1; rx_valid = 1'b0; rx_last = 1'b0; rx_data = 8'h00; evt_ready = 1'b1;
    repeat (3) @(posedge clk); #1;
    chk("rst_evt_valid", {31'd0, evt_valid}, 32'd0);
    chk("rst_evt_code", {24'd0, evt_code}, 32'd0);
    chk("rst_evt_press", {31'd0, evt_press}, 32'd0);
    chk("rst_modifiers", {24'd0, modifiers}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_report_err", {31'd0, report_err}, 32'd0);
    rst = 1'b0;
    repeat (2) @(posedge clk); #1;

    // Single key press from an all-zero previous report.
    e0 = evq.size(); b0 = busy_cnt;
    send(72'h00_00_04_00_00_00_00_00, 8);
    chk("busy_after_last", {31'd0, busy}, 32'd1);
    wait_idle();
    chk("p1_busy_cycles", busy_cnt - b0, 32'd29);
    chk("p1_count", evq.size() - e0, 32'd1);
    chk_ev(e0, 0, {1'b1, 8'h04});
    chk("p1_modifiers", {24'd0, modifiers}, 32'h00);

    // Release 04, press Left Shift, press 05.
    e0 = evq.size();
    send(72'h02_00_05_00_00_00_00_00, 8);
    chk("p2_mod_before_update", {24'd0, modifiers}, 32'h00);
    wait_idle();
    chk("p2_count", evq.size() - e0, 32'd3);
    chk_ev(e0, 0, {1'b0, 8'h04});
    chk_ev(e0, 1, {1'b1, 8'hE1});
    chk_ev(e0, 2, {1'b1, 8'h05});
    chk("p2_modifiers", {24'd0, modifiers}, 32'h02);

    // Short and long packets.
    e0 = evq.size(); r0 = err_cnt; b0 = busy_cnt;
    send(72'h00_00_06_00_00_00_00, 7);
    send(72'h00_00_07_00_00_00_00_00_00, 9);
    repeat (4) @(posedge clk); #1;
    chk("bad_err_pulses", err_cnt - r0, 32'd2);
    chk("bad_count", evq.size() - e0, 32'd0);
    chk("bad_busy_cycles", busy_cnt - b0, 32'd0);
    chk("bad_modifiers", {24'd0, modifiers}, 32'h02);

    // ErrorRollOver report is ignored; previous report survives.
    e0 = evq.size(); r0 = err_cnt; b0 = busy_cnt;
    send(72'h00_00_01_01_01_01_01_01, 8);
    repeat (40) @(posedge clk); #1;
    chk("ovr_count", evq.size() - e0, 32'd0);
    chk("ovr_err", err_cnt - r0, 32'd0);
    chk("ovr_busy_cycles", busy_cnt - b0, 32'd0);
    chk("ovr_modifiers", {24'd0, modifiers}, 32'h02);
    e0 = evq.size();
    send(72'h00_00_00_00_00_00_00_00, 8);
    wait_idle();
    chk("rel_count", evq.size() - e0, 32'd2);
    chk_ev(e0, 0, {1'b0, 8'hE1});
    chk_ev(e0, 1, {1'b0, 8'h05});
    chk("rel_modifiers", {24'd0, modifiers}, 32'h00);

    // A report arriving mid-scan is dropped with an error pulse.
    e0 = evq.size(); r0 = err_cnt;
    send(72'h00_00_0A_00_00_00_00_00, 8);
    send(72'h00_00_0B_00_00_00_00_00, 8);
    wait_idle();
    chk("drop_err", err_cnt - r0, 32'd1);
    chk("drop_count", evq.size() - e0, 32'd1);
    chk_ev(e0, 0, {1'b1, 8'h0A});
    e0 = evq.size();
    send(72'h00_00_00_00_00_00_00_00, 8);
    wait_idle();
    chk("drop_rel_count", evq.size() - e0, 32'd1);
    chk_ev(e0, 0, {1'b0, 8'h0A});

    // Six presses into a four-entry FIFO with the consumer stalled.
    evt_ready = 1'b0;
    e0 = evq.size();
    send(72'h00_00_04_05_06_07_08_09, 8);
    repeat (40) @(posedge clk); #1;
    chk("stall_busy", {31'd0, busy}, 32'd1);
    chk("stall_valid", {31'd0, evt_valid}, 32'd1);
    chk("stall_head_code", {24'd0, evt_code}, 32'h04);
    repeat (5) @(posedge clk); #1;
    chk("stall_hold_code", {24'd0, evt_code}, 32'h04);
    chk("stall_hold_press", {31'd0, evt_press}, 32'd1);
    evt_ready = 1'b1;
    wait_idle();
    chk("stall_count", evq.size() - e0, 32'd6);
    for (int i = 0; i < 6; i++) chk_ev(e0, i, {1'b1, 8'h04 + 8'(i)});

    // Reset mid-scan aborts it and clears the previous report.
    evt_ready = 1'b0;
    send(72'h00_00_00_00_00_00_00_00, 8);
    repeat (10) @(posedge clk); #1;
    chk("abort_pre_valid", {31'd0, evt_valid}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("abort_valid", {31'd0, evt_valid}, 32'd0);
    chk("abort_code", {24'd0, evt_code}, 32'd0);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    evt_ready = 1'b1;
    repeat (2) @(posedge clk); #1;
    e0 = evq.size(); b0 = busy_cnt;
    send(72'h00_00_00_00_00_00_00_00, 8);
    wait_idle();
    chk("abort_count", evq.size() - e0, 32'd0);
    chk("abort_busy_cycles", busy_cnt - b0, 32'd29);
    chk("abort_modifiers", {24'd0, modifiers}, 32'h00);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/usb_keyboard_report_rx.md
USB_KEYBOARD_REPORT_RX -- requirements
Module: usb_keyboard_report_rx

Interface
REQ-001 SHALL have parameter EVT_DEPTH, default 16, event FIFO depth in entries (power of 2, 4..64).
REQ-002 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port rx_data  input  8  HID boot keyboard report byte.
REQ-005 SHALL have port rx_valid  input  1  rx_data valid this cycle; no backpressure.
REQ-006 SHALL have port rx_last  input  1  qualified by rx_valid; marks last byte of a packet.
REQ-007 SHALL have port evt_code  output  8  HID usage code of the head event (0xE0..0xE7 for modifiers).
REQ-008 SHALL have port evt_press  output  1  1 = key pressed, 0 = key released.
REQ-009 SHALL have port evt_valid  output  1  head event available.
REQ-010 SHALL have port evt_ready  input  1  consumer accepts head event when evt_valid & evt_ready.
REQ-011 SHALL have port modifiers  output  8  byte 0 of the last committed report.
REQ-012 SHALL have port busy  output  1  diff scan in progress.
REQ-013 SHALL have port report_err  output  1  one-cycle pulse: malformed or dropped report.

Function
REQ-014 Report format: byte0 modifiers, byte1 reserved (ignored), bytes2..7 key slots 0..5.
REQ-015 Receiver SHALL count accepted bytes into a shadow buffer; bytes beyond the 8th are discarded and flag the packet bad.
REQ-016 On rx_valid & rx_last: packet with exactly 8 bytes and not bad SHALL commit; otherwise pulse report_err the next cycle, no events, previous report unchanged.
REQ-017 Byte counter and bad flag SHALL clear after every rx_last, so the next byte starts a new packet.
REQ-018 Committed report with any key slot == 0x01 (ErrorRollOver) SHALL be discarded silently: no events, no report_err, previous report retained.
REQ-019 Committed report while busy=1 SHALL be dropped and SHALL pulse report_err; the scan in progress is unaffected.
REQ-020 Commit SHALL set busy=1 the cycle after rx_last; state machine IDLE -> REL_MOD -> REL_KEY -> PRS_MOD -> PRS_KEY -> UPDATE -> IDLE.
REQ-021 REL_MOD: steps bit 0..7; old=1, new=0 pushes (0xE0+bit, press=0).
REQ-022 REL_KEY: steps old slot 0..5; nonzero code absent from all new slots and not equal to an earlier old slot pushes (code, 0).
REQ-023 PRS_MOD: bit 0..7; old=0, new=1 pushes (0xE0+bit, 1).
REQ-024 PRS_KEY: new slot 0..5; nonzero code absent from all old slots and not equal to an earlier new slot pushes (code, 1).
REQ-025 One step per cycle; a step that must push while the FIFO is full SHALL stall (no event lost); non-pushing steps never stall.
REQ-026 UPDATE SHALL copy new report into previous-report register and modifiers output; busy=0 the following cycle.
REQ-027 Unstalled scan SHALL take exactly 28 step cycles + 1 UPDATE cycle; first event visible on evt_valid at earliest 2 cycles after the rx_last cycle.
REQ-028 Event FIFO SHALL be first-word-fall-through; evt_code/evt_press hold stable while evt_valid=1 and evt_ready=0; simultaneous push and pop when full SHALL be permitted only after pop (no bypass).
REQ-029 Events SHALL leave in push order; evt_code/evt_press SHALL be 0 when evt_valid=0.

Reset
REQ-030 rst=1 SHALL asynchronously set: evt_valid=0, evt_code=0, evt_press=0, modifiers=0, busy=0, report_err=0, FIFO empty, previous report all-zero, byte counter 0, state IDLE.
REQ-031 rst asserted mid-packet or mid-scan SHALL abort it; no event of that report appears after release.

Verification
REQ-032 From reset, send 00 00 04 00 00 00 00 00 (last on 8th) -> exactly one event (0x04, press=1); modifiers=0x00; busy high 29 cycles.
REQ-033 Then send 02 00 05 00 00 00 00 00 -> events in order (0x04,0), (0xE1,1), (0x05,1); modifiers=0x02 after UPDATE.
REQ-034 Send 7-byte packet, then 9-byte packet -> report_err pulses twice, no events, modifiers unchanged.
REQ-035 Send 00 00 01 01 01 01 01 01 -> no events, no report_err, previous report retained; following all-zero report releases prior keys.
REQ-036 EVT_DEPTH=4, evt_ready=0, send 00 00 04 05 06 07 08 09 -> 4 events queued, busy stays 1; raise evt_ready -> remaining 2 delivered, total 6 presses codes 04..09 in order.
REQ-037 Assert rst during scan of REQ-036 -> evt_valid=0 immediately; after release, all-zero report produces no events.
